// File: rtl/pcspma_link_ctrl.sv
// Bring-up sequencer and link supervisor for the SGMII PCS/PMA core: reset, wait for sync,
// wait for autonegotiation, then watch the link, with timeout-driven recovery and event counters.
module pcspma_link_ctrl #(
    parameter int RESET_CYCLES = 1250,
    parameter int SYNC_TIMEOUT = 1250000,
    parameter int AN_TIMEOUT   = 2500000,
    parameter int LINK_FILTER  = 125,
    parameter int TIMER_WIDTH  = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] status_vector,
    input  logic        force_restart,
    output logic        pcs_reset,
    output logic        an_restart,
    output logic        speed_is_10_100,
    output logic        speed_is_100,
    output logic        link_up,
    output logic [2:0]  state,
    output logic [7:0]  retry_count,
    output logic [7:0]  link_drop_count
);
    localparam int FILT_W = $clog2(LINK_FILTER + 1);
    localparam logic [TIMER_WIDTH-1:0] RESET_LAST = TIMER_WIDTH'(RESET_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] SYNC_LAST  = TIMER_WIDTH'(SYNC_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] AN_LAST    = TIMER_WIDTH'(AN_TIMEOUT - 1);
    localparam logic [FILT_W-1:0]      FILT_LAST  = FILT_W'(LINK_FILTER - 1);

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_WAIT_SYNC  = 3'd1,
        ST_WAIT_AN    = 3'd2,
        ST_AN_RESTART = 3'd3,
        ST_LINK_UP    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [FILT_W-1:0]      filt_q, filt_d;
    logic [7:0]             retry_q, retry_d;
    logic [7:0]             drop_q, drop_d;
    logic                   pcs_reset_q, an_restart_q, link_up_q;
    logic                   spd_10_100_q, spd_10_100_d;
    logic                   spd_100_q, spd_100_d;
    logic                   retry_hit, drop_hit;

    logic       sync, link;
    logic [1:0] speed_code;
    logic       unused_status;

    assign link          = status_vector[0];
    assign sync          = status_vector[1];
    assign speed_code    = status_vector[11:10];
    assign unused_status = ^{status_vector[15:12], status_vector[9:2]};

    always_comb begin
        state_d      = state_q;
        filt_d       = '0;
        retry_hit    = 1'b0;
        drop_hit     = 1'b0;
        spd_10_100_d = spd_10_100_q;
        spd_100_d    = spd_100_q;

        if (force_restart) begin
            state_d = ST_RESET;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (timer_q == RESET_LAST) state_d = ST_WAIT_SYNC;
                end
                ST_WAIT_SYNC: begin
                    if (sync) begin
                        state_d = ST_WAIT_AN;
                    end else if (timer_q == SYNC_LAST) begin
                        state_d   = ST_RESET;
                        retry_hit = 1'b1;
                    end
                end
                ST_WAIT_AN: begin
                    // filt_q counts consecutive sync&link cycles already seen in this stay
                    filt_d = (sync && link) ? filt_q + 1'b1 : '0;
                    if (!sync) begin
                        state_d = ST_WAIT_SYNC;
                    end else if (link && filt_q == FILT_LAST) begin
                        state_d = ST_LINK_UP;
                    end else if (timer_q == AN_LAST) begin
                        state_d   = ST_AN_RESTART;
                        retry_hit = 1'b1;
                    end
                end
                ST_AN_RESTART: begin
                    state_d = ST_WAIT_AN;
                end
                ST_LINK_UP: begin
                    if (!sync) begin
                        state_d  = ST_WAIT_SYNC;
                        drop_hit = 1'b1;
                    end else if (!link) begin
                        state_d  = ST_WAIT_AN;
                        drop_hit = 1'b1;
                    end
                end
                default: state_d = ST_RESET;
            endcase
        end

        if (state_d != ST_WAIT_AN || state_q != ST_WAIT_AN) filt_d = '0;
        timer_d = (force_restart || state_d != state_q) ? '0 : timer_q + 1'b1;

        // Speed only tracks the PCS while the link stays up; exit cycles keep the last value.
        if (state_q == ST_LINK_UP && state_d == ST_LINK_UP) begin
            unique case (speed_code)
                2'b10:   begin spd_10_100_d = 1'b0; spd_100_d = 1'b0; end
                2'b01:   begin spd_10_100_d = 1'b1; spd_100_d = 1'b1; end
                2'b00:   begin spd_10_100_d = 1'b1; spd_100_d = 1'b0; end
                default: begin spd_10_100_d = spd_10_100_q; spd_100_d = spd_100_q; end
            endcase
        end

        retry_d = (retry_hit && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
        drop_d  = (drop_hit && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESET;
            timer_q      <= '0;
            filt_q       <= '0;
            retry_q      <= '0;
            drop_q       <= '0;
            pcs_reset_q  <= 1'b1;
            an_restart_q <= 1'b0;
            link_up_q    <= 1'b0;
            spd_10_100_q <= 1'b0;
            spd_100_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            filt_q       <= filt_d;
            retry_q      <= retry_d;
            drop_q       <= drop_d;
            pcs_reset_q  <= (state_d == ST_RESET);
            an_restart_q <= (state_d == ST_AN_RESTART);
            link_up_q    <= (state_d == ST_LINK_UP);
            spd_10_100_q <= spd_10_100_d;
            spd_100_q    <= spd_100_d;
        end
    end

    assign pcs_reset       = pcs_reset_q;
    assign an_restart      = an_restart_q;
    assign link_up         = link_up_q;
    assign speed_is_10_100 = spd_10_100_q;
    assign speed_is_100    = spd_100_q;
    assign state           = state_q;
    assign retry_count     = retry_q;
    assign link_drop_count = drop_q;

endmodule
